arbitro_eventos: RTL and testbench
==================================

# arbitro_eventos

Event arbiter between the debounced button/sensor outputs and the pet state machine. Rising edges on the five debounced sources become pending requests. They are granted one at a time over a valid/ready handshake. Test takes fixed priority and the other sources share round-robin. A programmable cool-down separates consecutive grants, so the consumer never sees two events in back-to-back cycles.

## Interface
- `COOLDOWN`, 50000: idle cycles enforced after each accepted event (0 = none); counter width `$clog2(COOLDOWN+1)`, minimum 1
- `clk`  input  1  system clock, all logic on rising edge
- `reset`  input  1  synchronous, active-low reset
- `energia`  input  1  debounced energy button level
- `medicina`  input  1  debounced medicine button level
- `test`  input  1  debounced test button level
- `fotocelda`  input  1  debounced photocell level
- `ultrasonido`  input  1  debounced ultrasonic sensor level
- `modo_test`  input  1  1 = sensor sources (fotocelda, ultrasonido) ignored
- `evt_ready`  input  1  consumer accepts current event
- `evt_valid`  output  1  event presented
- `evt_id`  output  3  source id: 0 energia, 1 medicina, 2 test, 3 fotocelda, 4 ultrasonido
- `pendiente`  output  5  pending-request flags, bit index = id
- `perdido`  output  1  sticky: an edge arrived while that source was already pending
- `ocupado`  output  1  state != IDLE

## Operation
- Reset (`reset`=0 at a clock edge) clears all of the following, overriding all other activity including a mid-handshake grant:
  - `evt_valid`, `evt_id`=0, `pendiente`=0, `perdido`=0
  - rr pointer=0, cool-down counter=0, state=IDLE
  - input history registers loaded with current input levels, so no spurious edge after reset
- Edge detection:
  - `edge[i] = in[i] & ~prev[i]`; `prev` is registered every cycle.
  - When `modo_test`=1, `edge[3]` and `edge[4]` are forced to 0; already-pending sensor bits stay pending.
- Pending update, per bit, in priority order:
  1. `edge[i]` sets the bit, even in the same cycle the bit is being cleared by a grant (set wins).
  2. Otherwise, a grant of `i` clears the bit.
  3. Otherwise, the bit holds.
- `perdido`: set when `edge[i]` occurs while `pendiente[i]` is already 1 and is not being cleared that cycle.
- FSM states: IDLE, GRANT, ESPERA.
  - IDLE: if `pendiente`≠0, select the winner, load `evt_id`, assert `evt_valid`, clear that pending bit, and go to GRANT.
  - GRANT: `evt_valid`=1 and `evt_id` stable until `evt_valid & evt_ready` at a clock edge. On acceptance, drop `evt_valid`. If `COOLDOWN`=0, go to IDLE; otherwise load counter=`COOLDOWN-1` and go to ESPERA.
  - ESPERA: decrement each cycle; at 0 go to IDLE.
- Selection rule:
  - Test (id 2) pending always wins.
  - Otherwise, round-robin over ids {0,1,3,4}, starting at the rr pointer, skipping ids that are not pending.
  - After granting an rr id, the pointer moves to the next id in the ring 0→1→3→4→0.
  - Granting test does not move the pointer.
- `evt_ready` is ignored outside GRANT.

## Timing
- Input rising before edge k → `pendiente` bit set after edge k.
- If IDLE, `evt_valid`=1 after edge k+1. Minimum latency is 2 cycles.
- Acceptance at edge a → `evt_valid`=0 after a.
- Next `evt_valid` no earlier than after edge a+`COOLDOWN`+1, i.e. `COOLDOWN` idle cycles plus the IDLE decision cycle.
  - With `COOLDOWN`=0, there is exactly 1 cycle gap.
- Held input level produces one event only. A new event needs a falling edge then a rising edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset:
  - Stimulus: hold all inputs at 1 during reset, release, wait 10 cycles.
  - Required: `pendiente`=0, `evt_valid`=0, `perdido`=0 throughout (no spurious edges).
- Single event (`COOLDOWN`=4):
  - Stimulus: pulse `medicina` high before edge 10; `evt_ready`=1.
  - Required: `pendiente`=5'b00010 after edge 10; `evt_valid`=1 with `evt_id`=1 after edge 11, dropped after edge 12; `ocupado`=1 through edge 16.
- Priority and round-robin:
  - Stimulus: `energia`, `medicina`, `test`, `ultrasonido` rise in the same cycle; `evt_ready` held 1.
  - Required: grant order 2, 0, 1, 4; pending empties after the fourth grant.
- Backpressure with set-wins:
  - Stimulus: `evt_ready`=0 for 20 cycles while `evt_id`=0 is presented; during that time `energia` falls and rises again.
  - Required: `evt_valid` and `evt_id` stable for all 20 cycles; `pendiente[0]`=1 again; `perdido` stays 0. A third `energia` edge before the grant sets `perdido`=1.
- Test mode:
  - Stimulus: `modo_test`=1; `fotocelda` edge, then `energia` edge.
  - Required: only `evt_id`=0 is granted; `pendiente[3]` never sets.
- Reset mid-operation:
  - Stimulus: assert `reset`=0 during GRANT and during ESPERA.
  - Required: next cycle `evt_valid`=0, `pendiente`=0, state IDLE; rr pointer returns to 0, so a subsequent simultaneous {0,1} request grants 0 first.

Source files
------------

// File: rtl/arbitro_eventos.sv
// arbitro_eventos: turns rising edges on five debounced sources into pending
// requests and hands them one at a time to the pet FSM over valid/ready.
// The test source has fixed priority; the other four share a round-robin ring
// (0 -> 1 -> 3 -> 4 -> 0). A cool-down separates consecutive grants.
//
//   state  | meaning
//   IDLE   | waiting for a pending request; picks the winner when one exists
//   GRANT  | event presented, holding evt_valid/evt_id until evt_ready
//   ESPERA | cool-down after an accepted event, counting down to zero
module arbitro_eventos #(
    parameter int unsigned COOLDOWN = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       energia,
    input  logic       medicina,
    input  logic       test,
    input  logic       fotocelda,
    input  logic       ultrasonido,
    input  logic       modo_test,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [2:0] evt_id,
    output logic [4:0] pendiente,
    output logic       perdido,
    output logic       ocupado
);

    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT  = 2'd1;
    localparam logic [1:0] S_ESPERA = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_rr_ptr;
    logic [4:0]    r_prev;
    logic [4:0]    r_pend;
    logic          r_perdido;
    logic          r_valid;
    logic [2:0]    r_id;

    logic [4:0]    w_in;
    logic [4:0]    w_edge;
    logic [3:0]    w_rr_req;
    logic          w_rr_found;
    logic [1:0]    w_rr_pos;
    logic [1:0]    w_pos;
    logic          w_grant;
    logic [2:0]    w_grant_id;
    logic [4:0]    w_clr;
    logic [4:0]    w_pend_nxt;
    logic          w_lost;

    assign w_in   = {ultrasonido, fotocelda, test, medicina, energia};
    // Sensor edges are masked in test mode; bits already pending are left alone.
    assign w_edge = w_in & ~r_prev & {~modo_test, ~modo_test, 3'b111};

    // Round-robin request vector indexed by ring position, not by source id.
    assign w_rr_req = {r_pend[4], r_pend[3], r_pend[1], r_pend[0]};

    // Find the first pending ring position starting from the pointer.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_pos   = r_rr_ptr;
        w_pos      = r_rr_ptr;
        for (int k = 0; k < 4; k++) begin
            w_pos = r_rr_ptr + 2'(k);
            if (!w_rr_found && w_rr_req[w_pos]) begin
                w_rr_found = 1'b1;
                w_rr_pos   = w_pos;
            end
        end
    end

    // Winner: test first, otherwise map the ring position back to a source id.
    always_comb begin
        w_grant    = (r_state == S_IDLE) && (r_pend != 5'b0);
        w_grant_id = 3'd0;
        if (r_pend[2]) begin
            w_grant_id = 3'd2;
        end else begin
            case (w_rr_pos)
                2'd0:    w_grant_id = 3'd0;
                2'd1:    w_grant_id = 3'd1;
                2'd2:    w_grant_id = 3'd3;
                default: w_grant_id = 3'd4;
            endcase
        end
        w_clr      = w_grant ? (5'b00001 << w_grant_id) : 5'b00000;
        // A fresh edge beats the clear of the same bit.
        w_pend_nxt = w_edge | (r_pend & ~w_clr);
        w_lost     = |(w_edge & r_pend & ~w_clr);
    end

    // Input history, pending flags and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev    <= w_in;
            r_pend    <= 5'b0;
            r_perdido <= 1'b0;
        end else begin
            r_prev    <= w_in;
            r_pend    <= w_pend_nxt;
            r_perdido <= r_perdido | w_lost;
        end
    end

    // Grant sequencing, round-robin pointer and cool-down timer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rr_ptr <= 2'd0;
            r_valid  <= 1'b0;
            r_id     <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_valid <= 1'b1;
                        r_id    <= w_grant_id;
                        r_state <= S_GRANT;
                        if (!r_pend[2]) begin
                            r_rr_ptr <= w_rr_pos + 2'd1;
                        end
                    end
                end
                S_GRANT: begin
                    if (evt_ready) begin
                        r_valid <= 1'b0;
                        if (COOLDOWN == 0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= CW'(COOLDOWN - 1);
                            r_state <= S_ESPERA;
                        end
                    end
                end
                S_ESPERA: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign evt_valid = r_valid;
    assign evt_id    = r_id;
    assign pendiente = r_pend;
    assign perdido   = r_perdido;
    assign ocupado   = (r_state != S_IDLE);

endmodule

// File: tb/tb_arbitro_eventos.sv
// Directed bench for arbitro_eventos with a short cool-down (4 cycles).
module tb_arbitro_eventos;

    logic       clk = 1'b0;
    logic       reset;
    logic       energia, medicina, test, fotocelda, ultrasonido;
    logic       modo_test;
    logic       evt_ready;
    logic       evt_valid;
    logic [2:0] evt_id;
    logic [4:0] pendiente;
    logic       perdido;
    logic       ocupado;

    int n_tests = 0;
    int n_fail  = 0;

    arbitro_eventos #(.COOLDOWN(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .energia     (energia),
        .medicina    (medicina),
        .test        (test),
        .fotocelda   (fotocelda),
        .ultrasonido (ultrasonido),
        .modo_test   (modo_test),
        .evt_ready   (evt_ready),
        .evt_valid   (evt_valid),
        .evt_id      (evt_id),
        .pendiente   (pendiente),
        .perdido     (perdido),
        .ocupado     (ocupado)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int got[4];
        int ng;
        logic [4:0] pend_at4;

        reset = 1'b0; modo_test = 1'b0; evt_ready = 1'b0;
        energia = 1'b1; medicina = 1'b1; test = 1'b1; fotocelda = 1'b1; ultrasonido = 1'b1;

        // Reset with all inputs high: no spurious edges afterwards.
        tick(); tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_pend", 32'(pendiente), 32'h0);
            chk("rst_valid", 32'(evt_valid), 32'h0);
            chk("rst_perdido", 32'(perdido), 32'h0);
        end
        chk("rst_ocupado", 32'(ocupado), 32'h0);
        energia = 1'b0; medicina = 1'b0; test = 1'b0; fotocelda = 1'b0; ultrasonido = 1'b0;
        tick(); tick();

        // Single event with cool-down 4.
        medicina = 1'b1;
        tick();
        chk("single_pend", 32'(pendiente), 32'h02);
        chk("single_valid0", 32'(evt_valid), 32'h0);
        evt_ready = 1'b1;
        tick();
        chk("single_valid1", 32'(evt_valid), 32'h1);
        chk("single_id", 32'(evt_id), 32'h1);
        chk("single_pend_clr", 32'(pendiente), 32'h0);
        tick();
        chk("single_drop", 32'(evt_valid), 32'h0);
        chk("single_busy_a", 32'(ocupado), 32'h1);
        tick(); tick(); tick();
        chk("single_busy_b", 32'(ocupado), 32'h1);
        tick();
        chk("single_idle", 32'(ocupado), 32'h0);
        medicina = 1'b0;
        tick();

        // Priority and round-robin from pointer 0.
        do_reset();
        energia = 1'b1; medicina = 1'b1; test = 1'b1; ultrasonido = 1'b1;
        ng = 0;
        pend_at4 = 5'h1f;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            tick();
            if (evt_valid) begin
                got[ng] = int'(evt_id);
                ng++;
                if (ng == 4) pend_at4 = pendiente;
            end
        end
        chk("rr_count", 32'(ng), 32'd4);
        chk("rr_g0", 32'(got[0]), 32'd2);
        chk("rr_g1", 32'(got[1]), 32'd0);
        chk("rr_g2", 32'(got[2]), 32'd1);
        chk("rr_g3", 32'(got[3]), 32'd4);
        chk("rr_pend_empty", 32'(pend_at4), 32'h0);
        chk("rr_perdido", 32'(perdido), 32'h0);
        energia = 1'b0; medicina = 1'b0; test = 1'b0; ultrasonido = 1'b0;

        // Backpressure, re-arm during GRANT, then overflow and set-wins.
        do_reset();
        evt_ready = 1'b0;
        energia = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 32'(evt_valid), 32'h1);
            chk("bp_id", 32'(evt_id), 32'h0);
            if (i == 4) energia = 1'b0;
            if (i == 8) energia = 1'b1;
            tick();
        end
        chk("bp_pend", 32'(pendiente), 32'h01);
        chk("bp_perdido0", 32'(perdido), 32'h0);
        energia = 1'b0;
        tick();
        energia = 1'b1;
        tick();
        chk("bp_perdido1", 32'(perdido), 32'h1);
        evt_ready = 1'b1;
        tick();
        chk("bp_accept", 32'(evt_valid), 32'h0);
        energia = 1'b0;
        tick(); tick(); tick(); tick();
        chk("bp_cooldown", 32'(evt_valid), 32'h0);
        energia = 1'b1;
        tick();
        chk("bp_regrant", 32'(evt_valid), 32'h1);
        chk("bp_regrant_id", 32'(evt_id), 32'h0);
        chk("bp_setwins", 32'(pendiente), 32'h01);
        energia = 1'b0;

        // Test mode masks sensor edges.
        do_reset();
        modo_test = 1'b1;
        evt_ready = 1'b1;
        fotocelda = 1'b1;
        tick();
        chk("tm_no_foto", 32'(pendiente), 32'h0);
        energia = 1'b1;
        tick();
        chk("tm_pend", 32'(pendiente), 32'h01);
        tick();
        chk("tm_valid", 32'(evt_valid), 32'h1);
        chk("tm_id", 32'(evt_id), 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("tm_no_more", 32'(evt_valid), 32'h0);
            chk("tm_pend3", 32'(pendiente[3]), 32'h0);
        end
        modo_test = 1'b0;
        energia = 1'b0; fotocelda = 1'b0;

        // Reset during GRANT.
        do_reset();
        evt_ready = 1'b0;
        energia = 1'b1; medicina = 1'b1;
        tick();
        tick();
        chk("mid_g_valid", 32'(evt_valid), 32'h1);
        chk("mid_g_id", 32'(evt_id), 32'h0);
        reset = 1'b0;
        tick();
        chk("mid_g_rvalid", 32'(evt_valid), 32'h0);
        chk("mid_g_rpend", 32'(pendiente), 32'h0);
        chk("mid_g_rbusy", 32'(ocupado), 32'h0);
        reset = 1'b1;
        energia = 1'b0; medicina = 1'b0;
        tick();

        // Reset during ESPERA after an energia grant moved the pointer.
        energia = 1'b1; evt_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_e_busy", 32'(ocupado), 32'h1);
        chk("mid_e_valid", 32'(evt_valid), 32'h0);
        reset = 1'b0;
        tick();
        chk("mid_e_rbusy", 32'(ocupado), 32'h0);
        chk("mid_e_rvalid", 32'(evt_valid), 32'h0);
        reset = 1'b1;
        energia = 1'b0;
        tick();
        energia = 1'b1; medicina = 1'b1;
        tick();
        chk("mid_e_pend", 32'(pendiente), 32'h03);
        tick();
        chk("mid_e_ptr_valid", 32'(evt_valid), 32'h1);
        chk("mid_e_ptr_id", 32'(evt_id), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
